// File: rtl/disp_mode_ctrl_pkg.sv
// Shared display timing types, mode table and totals helpers.
// Used by the mode controller, eof detector and pixel source.
package disp_mode_ctrl_pkg;

  typedef struct packed {
    logic [10:0] horz_pix;
    logic [10:0] horz_fp;
    logic [10:0] horz_sync;
    logic [10:0] horz_bp;
    logic [10:0] vert_pix;
    logic [10:0] vert_fp;
    logic [10:0] vert_sync;
    logic [10:0] vert_bp;
  } t_sync;

  typedef logic [1:0] t_mode_state;

  localparam t_mode_state ST_IDLE      = 2'd0;
  localparam t_mode_state ST_MUTE_WAIT = 2'd1;
  localparam t_mode_state ST_SETTLE    = 2'd2;
  localparam t_mode_state ST_DONE      = 2'd3;

  localparam t_sync MODE_TABLE [4] = '{
    '{11'd640,  11'd16,  11'd96,  11'd48,
      11'd480,  11'd10,  11'd2,   11'd33},
    '{11'd800,  11'd40,  11'd128, 11'd88,
      11'd600,  11'd1,   11'd4,   11'd23},
    '{11'd1280, 11'd110, 11'd40,  11'd220,
      11'd720,  11'd5,   11'd5,   11'd20},
    '{11'd1024, 11'd24,  11'd136, 11'd160,
      11'd768,  11'd3,   11'd6,   11'd29}
  };

  function automatic logic [11:0] htot(
    input t_sync s
  );
    return {1'b0, s.horz_pix}
         + {1'b0, s.horz_fp}
         + {1'b0, s.horz_sync}
         + {1'b0, s.horz_bp};
  endfunction

  function automatic logic [11:0] vtot(
    input t_sync s
  );
    return {1'b0, s.vert_pix}
         + {1'b0, s.vert_fp}
         + {1'b0, s.vert_sync}
         + {1'b0, s.vert_bp};
  endfunction

endpackage

// File: rtl/disp_mode_ctrl_eof.sv
// disp_eof_det: combinational end-of-frame compare of x/y against sp.
// Shared with the pixel source so both agree on the frame boundary.
module disp_eof_det
  import disp_mode_ctrl_pkg::*;
(
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  t_sync       sp,
  output logic        eof
);

  logic [11:0] hlast;
  logic [11:0] vlast;

  assign hlast = htot(sp) - 12'd1;
  assign vlast = vtot(sp) - 12'd1;

  assign eof = ({1'b0, x} == hlast)
            && ({1'b0, y} == vlast);

endmodule

// File: rtl/disp_mode_ctrl.sv
// Runtime video-mode controller: muted, frame-aligned timing swaps.
// Optional MODE_CTRL_STATS_EN adds frame_cnt / switch_cnt outputs.
module disp_mode_ctrl
  import disp_mode_ctrl_pkg::*;
#(
  parameter int unsigned RESET_MODE    = 0,
  parameter int unsigned SETTLE_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic        req_valid,
  input  logic [1:0]  req_mode,
  output logic        req_ready,
  output logic        done,
  output logic        busy,
  output logic        mute,
  output logic [1:0]  cur_mode,
  output t_sync       sp
`ifdef MODE_CTRL_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [7:0]  switch_cnt
`endif
);

  localparam logic [1:0] RST_MODE = RESET_MODE[1:0];
  localparam logic [3:0] SETTLE_N = SETTLE_FRAMES[3:0];

  t_mode_state state;
  logic [1:0]  pend;
  logic [3:0]  fcnt;
  logic        changed;
  logic        eof;

  disp_eof_det u_eof (
    .x   (x),
    .y   (y),
    .sp  (sp),
    .eof (eof)
  );

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      sp       <= MODE_TABLE[RST_MODE];
      cur_mode <= RST_MODE;
      mute     <= 1'b0;
      done     <= 1'b0;
      fcnt     <= 4'd0;
      pend     <= 2'd0;
      changed  <= 1'b0;
    end else begin
      done <= (state == ST_DONE);
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            pend <= req_mode;
            if (req_mode == cur_mode) begin
              changed <= 1'b0;
              state   <= ST_DONE;
            end else begin
              changed <= 1'b1;
              mute    <= 1'b1;
              state   <= ST_MUTE_WAIT;
            end
          end
        end
        // eof here is still measured against the old timing
        ST_MUTE_WAIT: begin
          if (eof) begin
            sp       <= MODE_TABLE[pend];
            cur_mode <= pend;
            fcnt     <= 4'd0;
            state    <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (eof) begin
            if (fcnt + 4'd1 == SETTLE_N) begin
              mute  <= 1'b0;
              state <= ST_DONE;
            end else begin
              fcnt <= fcnt + 4'd1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef MODE_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt  <= 16'd0;
      switch_cnt <= 8'd0;
    end else begin
      if (eof) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (state == ST_DONE && changed
          && switch_cnt != 8'hFF) begin
        switch_cnt <= switch_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_disp_mode_ctrl.sv
// Bench for disp_mode_ctrl: directed vector table plus random run
// against a cycle-count reference model.
module tb_disp_mode_ctrl;
  import disp_mode_ctrl_pkg::*;

  localparam int RMODE  = 0;
  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] x, y;
  logic        req_valid;
  logic [1:0]  req_mode;
  logic        req_ready, done, busy, mute;
  logic [1:0]  cur_mode;
  t_sync       sp;
`ifdef MODE_CTRL_STATS_EN
  logic [15:0] frame_cnt;
  logic [7:0]  switch_cnt;
`endif

  disp_mode_ctrl #(
    .RESET_MODE    (RMODE),
    .SETTLE_FRAMES (SETTLE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .x          (x),
    .y          (y),
    .req_valid  (req_valid),
    .req_mode   (req_mode),
    .req_ready  (req_ready),
    .done       (done),
    .busy       (busy),
    .mute       (mute),
    .cur_mode   (cur_mode),
    .sp         (sp)
`ifdef MODE_CTRL_STATS_EN
    ,
    .frame_cnt  (frame_cnt),
    .switch_cnt (switch_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // bench-side copies of the mode timings
  t_sync tb_tab [4];
  int    htab   [4] = '{800, 1056, 1650, 1344};
  int    vtab   [4] = '{525, 628, 750, 806};

  // reference model: cycle bookkeeping, not a state machine copy
  int cyc;
  int m_mode, m_tgt, m_left, m_bu, m_da;
  bit m_mute, m_sw, m_swp, m_dchg;
  int m_fc, m_sc;

  task automatic model_edge(input bit r, input int xv, input int yv,
                            input bit v, input int m);
    bit eof, rdy;
    if (r) begin
      m_mode = RMODE; m_mute = 0; m_sw = 0; m_swp = 0;
      m_bu = -1; m_da = -1; m_dchg = 0; m_fc = 0; m_sc = 0;
    end else begin
      eof = (xv == htab[m_mode] - 1) && (yv == vtab[m_mode] - 1);
      if (eof) m_fc = (m_fc + 1) % 65536;
      rdy = !m_sw && (cyc > m_bu);
      if (rdy && v) begin
        if (m == m_mode) begin
          m_bu = cyc + 1; m_da = cyc + 2; m_dchg = 0;
        end else begin
          m_sw = 1; m_swp = 0; m_tgt = m;
          m_left = SETTLE; m_mute = 1;
        end
      end else if (m_sw && eof) begin
        if (!m_swp) begin
          m_mode = m_tgt; m_swp = 1;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_mute = 0; m_sw = 0; m_dchg = 1;
            m_bu = cyc + 1; m_da = cyc + 2;
          end
        end
      end
      if (cyc + 1 == m_da && m_dchg && m_sc < 255) m_sc++;
    end
    cyc++;
  endtask

  task automatic step(input bit r, input int xv, input int yv,
                      input bit v, input int m);
    rst = r; x = 11'(xv); y = 11'(yv);
    req_valid = v; req_mode = 2'(m);
    @(posedge clk);
    model_edge(r, xv, yv, v, m);
    #1;
  endtask

  typedef struct {
    int r, x, y, v, m;
    int mu, dn, bz, md;
  } vec_t;

  vec_t tv [32];

  task automatic check_model(input string nm);
    logic [5:0] got, exp;
    bit ok;
    got = {mute, done, busy, req_ready, cur_mode};
    exp = {m_mute, (cyc == m_da), (m_sw || cyc <= m_bu),
           !(m_sw || cyc <= m_bu), 2'(m_mode)};
    ok = (got == exp) && (sp == tb_tab[m_mode]);
`ifdef MODE_CTRL_STATS_EN
    ok = ok && (frame_cnt == 16'(m_fc)) && (switch_cnt == 8'(m_sc));
`endif
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%b exp=%b sp_pix=%0d exp_pix=%0d",
               nm, cyc, got, exp, sp.horz_pix, tb_tab[m_mode].horz_pix);
`ifdef MODE_CTRL_STATS_EN
      $display("  stats got fc=%0d sc=%0d exp fc=%0d sc=%0d",
               frame_cnt, switch_cnt, m_fc, m_sc);
`endif
    end
  endtask

  initial begin
    tb_tab[0] = '{11'd640, 11'd16, 11'd96, 11'd48,
                  11'd480, 11'd10, 11'd2, 11'd33};
    tb_tab[1] = '{11'd800, 11'd40, 11'd128, 11'd88,
                  11'd600, 11'd1, 11'd4, 11'd23};
    tb_tab[2] = '{11'd1280, 11'd110, 11'd40, 11'd220,
                  11'd720, 11'd5, 11'd5, 11'd20};
    tb_tab[3] = '{11'd1024, 11'd24, 11'd136, 11'd160,
                  11'd768, 11'd3, 11'd6, 11'd29};

    //          r  x     y    v  m   mute done busy mode
    tv[0]  = '{1, 0,    0,   0, 0,  0, 0, 0, 0};
    tv[1]  = '{0, 0,    0,   0, 0,  0, 0, 0, 0};
    tv[2]  = '{0, 10,   0,   1, 0,  0, 0, 1, 0};
    tv[3]  = '{0, 11,   0,   0, 0,  0, 1, 0, 0};
    tv[4]  = '{0, 12,   0,   0, 0,  0, 0, 0, 0};
    tv[5]  = '{0, 100,  50,  1, 2,  1, 0, 1, 0};
    tv[6]  = '{0, 200,  50,  0, 0,  1, 0, 1, 0};
    tv[7]  = '{0, 799,  524, 0, 0,  1, 0, 1, 2};
    tv[8]  = '{0, 0,    0,   0, 0,  1, 0, 1, 2};
    tv[9]  = '{0, 1649, 749, 0, 0,  1, 0, 1, 2};
    tv[10] = '{0, 799,  524, 0, 0,  1, 0, 1, 2};
    tv[11] = '{0, 1649, 749, 0, 0,  0, 0, 1, 2};
    tv[12] = '{0, 0,    0,   0, 0,  0, 1, 0, 2};
    tv[13] = '{0, 1,    0,   0, 0,  0, 0, 0, 2};
    tv[14] = '{0, 1649, 749, 1, 1,  1, 0, 1, 2};
    tv[15] = '{0, 0,    0,   0, 0,  1, 0, 1, 2};
    tv[16] = '{0, 1649, 749, 0, 0,  1, 0, 1, 1};
    tv[17] = '{0, 1055, 627, 0, 0,  1, 0, 1, 1};
    tv[18] = '{0, 1055, 627, 0, 0,  0, 0, 1, 1};
    tv[19] = '{0, 0,    0,   0, 0,  0, 1, 0, 1};
    tv[20] = '{0, 0,    0,   1, 3,  1, 0, 1, 1};
    tv[21] = '{0, 1055, 627, 0, 0,  1, 0, 1, 3};
    tv[22] = '{0, 5,    0,   1, 0,  1, 0, 1, 3};
    tv[23] = '{0, 1343, 805, 0, 0,  1, 0, 1, 3};
    tv[24] = '{0, 1343, 805, 1, 1,  0, 0, 1, 3};
    tv[25] = '{0, 0,    0,   1, 1,  0, 1, 0, 3};
    tv[26] = '{0, 0,    0,   0, 0,  0, 0, 0, 3};
    tv[27] = '{0, 0,    0,   1, 1,  1, 0, 1, 3};
    tv[28] = '{0, 1343, 805, 0, 0,  1, 0, 1, 1};
    tv[29] = '{0, 1055, 627, 0, 0,  1, 0, 1, 1};
    tv[30] = '{1, 0,    0,   0, 0,  0, 0, 0, 0};
    tv[31] = '{0, 0,    0,   0, 0,  0, 0, 0, 0};

    cyc = 0;
    m_mode = RMODE; m_bu = -1; m_da = -1;
    rst = 1'b1; x = '0; y = '0;
    req_valid = 1'b0; req_mode = '0;

    for (int i = 0; i < 32; i++) begin
      logic [5:0] got, exp;
      step(tv[i].r != 0, tv[i].x, tv[i].y, tv[i].v != 0, tv[i].m);
      got = {mute, done, busy, req_ready, cur_mode};
      exp = {tv[i].mu != 0, tv[i].dn != 0, tv[i].bz != 0,
             tv[i].bz == 0, 2'(tv[i].md)};
      n_vec++;
      if (got != exp || sp != tb_tab[tv[i].md]) begin
        n_bad++;
        $display("FAIL vec%0d got=%b exp=%b sp_pix=%0d exp_pix=%0d",
                 i, got, exp, sp.horz_pix, tb_tab[tv[i].md].horz_pix);
      end
    end

    // seq: three quiet frames of mode 0 then one real switch
    for (int i = 0; i < 3; i++) begin
      step(0, 5, 5, 0, 0);
      step(0, 799, 524, 0, 0);
      check_model("frames");
    end
    step(0, 0, 0, 1, 1);
    check_model("sw_accept");
    for (int i = 0; i < 6; i++) begin
      step(0, 1055, 627, 0, 0);
      step(0, 799, 524, 0, 0);
      check_model("sw_run");
    end

    for (int i = 0; i < 4000; i++) begin
      int r, v, m, xv, yv, pick, em;
      r = ($urandom_range(0, 299) == 0) ? 1 : 0;
      v = ($urandom_range(0, 7) == 0) ? 1 : 0;
      m = $urandom_range(0, 3);
      pick = $urandom_range(0, 99);
      if (pick < 30) begin
        xv = htab[m_mode] - 1; yv = vtab[m_mode] - 1;
      end else if (pick < 40) begin
        em = $urandom_range(0, 3);
        xv = htab[em] - 1; yv = vtab[em] - 1;
      end else begin
        xv = $urandom_range(0, 2047);
        yv = $urandom_range(0, 2047);
      end
      step(r != 0, xv, yv, v != 0, m);
      check_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/disp_mode_ctrl.md
Name: disp_mode_ctrl

Overview:
- Runtime video-mode controller for the display timing generator.
- Holds a table of timing modes and drives the generator's `t_sync` parameter input.
- Accepts mode-change requests over a valid/ready handshake and mutes video while switching.
- Swaps timing only at an end-of-frame boundary, waits a settle period under the new timing, then unmutes and reports completion.

Parameters:
- RESET_MODE, 0, mode index loaded on reset (0..3).
- SETTLE_FRAMES, 2, muted frames counted under the new timing before unmute; legal range 1..15.

Ports:
- clk  in  1  pixel clock, shared with the timing generator
- rst  in  1  synchronous, active-high reset
- x  in  11  horizontal counter from the timing generator
- y  in  11  vertical counter from the timing generator
- req_valid  in  1  mode-change request
- req_mode  in  2  requested mode index
- req_ready  out  1  high only in IDLE
- done  out  1  one-cycle pulse when a request completes
- busy  out  1  high in any state other than IDLE
- mute  out  1  video mute; the pixel source forces black while high
- cur_mode  out  2  mode currently driven on sp
- sp  out  t_sync  timing parameters to the generator

Behaviour:
- Reset (synchronous): state=IDLE, sp=MODE_TABLE[RESET_MODE], cur_mode=RESET_MODE, mute=0, done=0, busy=0, frame counter=0, pending mode=0.
- A reset asserted mid-switch abandons the switch immediately with the same values.
- eof (combinational) = (x == htot(sp)-1) && (y == vtot(sp)-1).
  - Totals use 12-bit unsigned arithmetic; x and y are zero-extended.
- States:
  - IDLE: req_ready=1. On req_valid && req_ready, latch req_mode.
    - If req_mode == cur_mode: go to DONE; mute stays 0.
    - Otherwise: set mute=1 on the next edge and go to MUTE_WAIT.
  - MUTE_WAIT: wait for the first eof strictly after the acceptance cycle. An eof in the acceptance cycle itself is ignored.
    - On eof: sp <= MODE_TABLE[pending] and cur_mode <= pending on that edge. The generator therefore sees the new parameters from x=0, y=0 onward.
    - Clear the frame counter; go to SETTLE.
  - SETTLE: count eof events, evaluated with the new sp. When the count reaches SETTLE_FRAMES: mute <= 0, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- req_valid outside IDLE is ignored; no queueing.
- req_mode is sampled only in the accept cycle.
- Latency from accept to done, non-trivial switch:
  - up to one frame of old timing to reach eof,
  - plus SETTLE_FRAMES frames of new timing,
  - plus 1 cycle.
- Same-mode request: done pulses 2 cycles after accept.
- sp and cur_mode change only in MUTE_WAIT on eof, or on reset.

Optional Feature:
- MODE_CTRL_STATS_EN defined:
  - Adds output frame_cnt[15:0], incremented on every eof in any state; wraps 0xFFFF->0; cleared by rst.
  - Adds output switch_cnt[7:0], incremented on every DONE that followed an actual mode change; saturates at 0xFF.
- Undefined: neither port nor any counter logic exists.

Decomposition:
- Extend pkg_disp with:
  - MODE_TABLE, a constant t_sync[4]:
    - mode 0: 640x480, H 16/96/48, V 10/2/33; totals 800x525.
    - mode 1: 800x600, H 40/128/88, V 1/4/23; totals 1056x628.
    - mode 2: 1280x720, H 110/40/220, V 5/5/20; totals 1650x750.
    - mode 3: 1024x768, H 24/136/160, V 3/6/29; totals 1344x806.
  - Functions htot(t_sync) and vtot(t_sync).
  - The state enum t_mode_state.
- One sub-module: disp_eof_det, the registered-free eof comparator for x/y/sp. It is reused by the pixel source.

Test Plan:
- Reset with RESET_MODE=0 -> sp.horz_pix=640, cur_mode=0, mute=0, req_ready=1, busy=0.
- Mode 0 -> 2 request mid-frame (x=100, y=50), generator connected:
  - mute rises the next cycle;
  - sp.horz_pix becomes 1280 on the edge where x=799, y=524;
  - after 2 full 1650x750 frames, mute falls and done pulses once; cur_mode=2.
- Request mode 0 while cur_mode=0 -> done pulses 2 cycles after accept; mute never rises; sp unchanged.
- Accept in the exact cycle x=799, y=524 -> switch deferred to the following eof, one full muted frame later.
- req_valid pulsed for mode 3 while in SETTLE -> ignored, req_ready=0; after done, cur_mode still equals the original target.
- rst asserted in SETTLE -> next cycle sp=MODE_TABLE[RESET_MODE], mute=0, state IDLE, no done pulse.
- With MODE_CTRL_STATS_EN defined: run 3 frames plus one real switch -> frame_cnt and switch_cnt match the counts expected from the eof events in the run and the single completed switch.
